proc_io_stream: RTL and testbench
=================================

Name: proc_io_stream

Overview:
- Peripheral-side responder for the processor's decoded I/O strobes. It is the other end of the one-hot `req_in` / `out_en` interface that the processor wrapper generates through its address decoders.
- Each processor input port k has a first-word-fall-through (FWFT) FIFO, filled from an external valid/ready stream. The head of FIFO k is presented on `io_in` and popped when `req_in[k]` strobes.
- Each processor output port k captures `io_out` into an output FIFO when `out_en[k]` strobes. That FIFO drains to an external valid/ready stream.
- Sits between the processor wrapper and the data sources and sinks (ADC, DMA, host bridge).

Parameters:
- NUIOIN, 4, number of processor input ports (width of `req_in`)
- NUIOOU, 4, number of processor output ports (width of `out_en`)
- NBIN, 19, processor input word width (signed)
- NBOUT, 28, processor output word width (signed)
- FDEPTH, 8, depth of every FIFO; power of 2, ≥2
- FAW, 3, log2(FDEPTH)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous active-low reset
- s_data  in  NUIOIN*NBIN  ingress words; port k occupies bits [k*NBIN +: NBIN]
- s_valid  in  NUIOIN  ingress valid per port
- s_ready  out  NUIOIN  ingress ready per port
- req_in  in  NUIOIN  one-cycle read strobe from the processor, one-hot
- io_in  out  NBIN  word returned to the processor, combinational
- out_en  in  NUIOOU  one-cycle write strobe from the processor, one-hot
- io_out  in  NBOUT  word written by the processor
- m_data  out  NUIOOU*NBOUT  egress words; port k occupies bits [k*NBOUT +: NBOUT]
- m_valid  out  NUIOOU  egress valid per port
- m_ready  in  NUIOOU  egress ready per port
- clr_err  in  1  synchronous clear of the sticky flags
- underrun  out  NUIOIN  sticky: processor read input port k while its FIFO was empty
- overflow  out  NUIOOU  sticky: processor write to output port k was dropped because its FIFO was full

Behaviour:
- Reset (rst=0, asynchronous):
  - all FIFO pointers and counts go to 0;
  - `underrun` and `overflow` go to 0;
  - `s_ready` is all 1s, `m_valid` is all 0s, `io_in` = 0 (no strobe is active).
  - Reset in the middle of traffic discards all FIFO contents; no partial word survives.
- Each FIFO:
  - circular buffer, write pointer and read pointer FAW bits wide, wrapping modulo FDEPTH;
  - count is FAW+1 bits, range 0..FDEPTH;
  - full when count==FDEPTH, empty when count==0.
- Input side, port k:
  - push when s_valid[k]&&s_ready[k];
  - s_ready[k] = (count_k != FDEPTH). It does not depend on a same-cycle pop.
- Read select:
  - sel = index of the lowest set bit of `req_in`;
  - other set bits are ignored and their FIFOs are not popped;
  - the one-hot property is guaranteed upstream, so this rule only covers a protocol error.
- io_in:
  - = head word of FIFO sel when `req_in`≠0 and FIFO sel is non-empty;
  - = 0 otherwise.
  - Purely combinational: zero cycles from strobe to data, so the processor samples it in the same cycle.
- Read pop: at the clock edge with req_in[sel]=1 and FIFO sel non-empty, FIFO sel pops.
- Empty read:
  - if FIFO sel is empty at the strobe edge, `io_in`=0, nothing pops, and underrun[sel] is set;
  - a word pushed in that same cycle is kept and is not consumed.
- Simultaneous push and pop on a non-empty, non-full input FIFO: count is unchanged and both pointers advance.
- Output side, port k:
  - at the edge with out_en[k]=1 (lowest index only, same rule as `req_in`), `io_out` is pushed into output FIFO k;
  - if that FIFO is full, the word is dropped and overflow[k] is set.
- Write-through latency: a word written with out_en[k] at edge N appears on m_data[k] with m_valid[k]=1 after edge N. The FIFO is FWFT, so latency is 1 cycle.
- Egress: pop when m_valid[k]&&m_ready[k], with m_valid[k] = (count != 0).
- Simultaneous processor write and egress pop:
  - FIFO not full: both happen.
  - FIFO full: the pop happens and the write is still dropped. The full test is taken before the pop, which is the conservative choice.
- Sticky flags:
  - hold until `clr_err`=1 at a clock edge;
  - if an error event occurs in the same cycle as `clr_err`, the flag ends up set (set wins).
- Data is passed through untouched: no sign extension and no truncation. Widths are exactly NBIN and NBOUT.

Test Plan:
- Reset, then push 0x00001, 0x7FFFF, 0x40000 on port 2. Then strobe req_in=4'b0100 on three cycles → io_in shows 0x00001, 0x7FFFF, 0x40000 in each strobe cycle; s_ready[2] stays 1; underrun=0.
- Fill port 0 with 8 words → s_ready[0]=0 after the 8th push. A 9th s_valid is not accepted. One strobe req_in=4'b0001 → s_ready[0]=1 on the next cycle, and read order shows the pointer wrap is correct.
- req_in=4'b1000 with port 3 empty → io_in=0, underrun=4'b1000 sticky. clr_err=1 for one cycle → underrun=0. clr_err in the same cycle as another empty read → underrun[3] stays 1.
- out_en=4'b0010 with io_out=28'h8000001, m_ready[1]=0 → m_valid[1]=1 one cycle later, m_data[1]=28'h8000001. Nine writes with m_ready held low → the 9th write is dropped and overflow[1]=1. Draining with m_ready=1 returns the first 8 words in order.
- Assert rst=0 asynchronously mid-burst with FIFOs half full → m_valid=0, s_ready=1111, flags cleared immediately without waiting for a clock edge. After release, the first read of port 0 underruns.
- req_in=4'b0110, both FIFOs non-empty → io_in = head of port 1; only port 1 pops; port 2's count is unchanged.

Source files
------------

// File: rtl/proc_io_stream.sv
// proc_io_stream: peripheral responder for the processor's one-hot I/O strobes.
// Per-port FWFT FIFOs feed io_in from ingress streams and capture io_out into egress streams.
module proc_io_stream #(
    parameter int NUIOIN = 4,
    parameter int NUIOOU = 4,
    parameter int NBIN   = 19,
    parameter int NBOUT  = 28,
    parameter int FDEPTH = 8,
    parameter int FAW    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUIOIN*NBIN-1:0]   s_data,
    input  logic [NUIOIN-1:0]        s_valid,
    output logic [NUIOIN-1:0]        s_ready,
    input  logic [NUIOIN-1:0]        req_in,
    output logic [NBIN-1:0]          io_in,
    input  logic [NUIOOU-1:0]        out_en,
    input  logic [NBOUT-1:0]         io_out,
    output logic [NUIOOU*NBOUT-1:0]  m_data,
    output logic [NUIOOU-1:0]        m_valid,
    input  logic [NUIOOU-1:0]        m_ready,
    input  logic                     clr_err,
    output logic [NUIOIN-1:0]        underrun,
    output logic [NUIOOU-1:0]        overflow
);
    localparam logic [FAW:0]        LP_FULL   = (FAW+1)'(FDEPTH);
    localparam logic [FAW:0]        LP_ZERO   = {(FAW+1){1'b0}};
    localparam logic [FAW:0]        LP_CNT1   = (FAW+1)'(1);
    localparam logic [FAW-1:0]      LP_PTR1   = FAW'(1);
    localparam logic [NUIOIN-1:0]   LP_IN_ONE = NUIOIN'(1);
    localparam logic [NUIOOU-1:0]   LP_OU_ONE = NUIOOU'(1);

    // Isolate the lowest set bit so a protocol-violating multi-hot strobe touches one port only.
    logic [NUIOIN-1:0] w_rd_oh;
    logic [NUIOOU-1:0] w_wr_oh;
    assign w_rd_oh = req_in & (~req_in + LP_IN_ONE);
    assign w_wr_oh = out_en & (~out_en + LP_OU_ONE);

    logic [NBIN-1:0]   w_in_head [NUIOIN];
    logic [NUIOIN-1:0] w_in_ne;
    logic [NUIOIN-1:0] w_ur_set;
    logic [NUIOOU-1:0] w_of_set;
    logic [NUIOIN-1:0] r_underrun;
    logic [NUIOOU-1:0] r_overflow;

    for (genvar k = 0; k < NUIOIN; k++) begin : g_in
        logic [NBIN-1:0] r_mem [FDEPTH];
        logic [FAW-1:0]  r_wp;
        logic [FAW-1:0]  r_rp;
        logic [FAW:0]    r_cnt;
        logic            w_push;
        logic            w_pop;

        assign w_push       = s_valid[k] && (r_cnt != LP_FULL);
        assign w_pop        = w_rd_oh[k] && (r_cnt != LP_ZERO);
        assign w_ur_set[k]  = w_rd_oh[k] && (r_cnt == LP_ZERO);
        assign w_in_ne[k]   = (r_cnt != LP_ZERO);
        assign w_in_head[k] = r_mem[r_rp];
        assign s_ready[k]   = (r_cnt != LP_FULL);

        // Ingress storage; entries are only observable once counted, so no reset.
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wp] <= s_data[k*NBIN +: NBIN];
            end else begin
                r_mem[r_wp] <= r_mem[r_wp];
            end
        end

        // Ingress pointers and occupancy.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_wp  <= {FAW{1'b0}};
                r_rp  <= {FAW{1'b0}};
                r_cnt <= LP_ZERO;
            end else begin
                r_wp <= w_push ? r_wp + LP_PTR1 : r_wp;
                r_rp <= w_pop  ? r_rp + LP_PTR1 : r_rp;
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + LP_CNT1;
                    2'b01:   r_cnt <= r_cnt - LP_CNT1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    for (genvar k = 0; k < NUIOOU; k++) begin : g_out
        logic [NBOUT-1:0] r_mem [FDEPTH];
        logic [FAW-1:0]   r_wp;
        logic [FAW-1:0]   r_rp;
        logic [FAW:0]     r_cnt;
        logic             w_push;
        logic             w_pop;

        // Full is judged before any same-cycle drain, so a write to a full FIFO is always dropped.
        assign w_push      = w_wr_oh[k] && (r_cnt != LP_FULL);
        assign w_of_set[k] = w_wr_oh[k] && (r_cnt == LP_FULL);
        assign w_pop       = m_ready[k] && (r_cnt != LP_ZERO);
        assign m_valid[k]  = (r_cnt != LP_ZERO);
        assign m_data[k*NBOUT +: NBOUT] = r_mem[r_rp];

        // Egress storage.
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wp] <= io_out;
            end else begin
                r_mem[r_wp] <= r_mem[r_wp];
            end
        end

        // Egress pointers and occupancy.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_wp  <= {FAW{1'b0}};
                r_rp  <= {FAW{1'b0}};
                r_cnt <= LP_ZERO;
            end else begin
                r_wp <= w_push ? r_wp + LP_PTR1 : r_wp;
                r_rp <= w_pop  ? r_rp + LP_PTR1 : r_rp;
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + LP_CNT1;
                    2'b01:   r_cnt <= r_cnt - LP_CNT1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    // Same-cycle head selection; zero when no strobe or the selected FIFO is empty.
    always_comb begin
        io_in = {NBIN{1'b0}};
        for (int k = 0; k < NUIOIN; k++) begin
            io_in = io_in | ({NBIN{w_rd_oh[k] && w_in_ne[k]}} & w_in_head[k]);
        end
    end

    // Sticky error flags; a new event in the clearing cycle wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_underrun <= {NUIOIN{1'b0}};
            r_overflow <= {NUIOOU{1'b0}};
        end else if (clr_err) begin
            r_underrun <= w_ur_set;
            r_overflow <= w_of_set;
        end else begin
            r_underrun <= r_underrun | w_ur_set;
            r_overflow <= r_overflow | w_of_set;
        end
    end

    assign underrun = r_underrun;
    assign overflow = r_overflow;
endmodule

// File: tb/tb_proc_io_stream.sv
// Randomized bench for proc_io_stream against a queue-based behavioural model.
module tb_proc_io_stream;
    localparam int NI = 4;
    localparam int NO = 4;
    localparam int BI = 19;
    localparam int BO = 28;
    localparam int FD = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NI*BI-1:0]  s_data;
    logic [NI-1:0]     s_valid;
    logic [NI-1:0]     s_ready;
    logic [NI-1:0]     req_in;
    logic [BI-1:0]     io_in;
    logic [NO-1:0]     out_en;
    logic [BO-1:0]     io_out;
    logic [NO*BO-1:0]  m_data;
    logic [NO-1:0]     m_valid;
    logic [NO-1:0]     m_ready;
    logic              clr_err;
    logic [NI-1:0]     underrun;
    logic [NO-1:0]     overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [BI-1:0] qin  [NI][$];
    logic [BO-1:0] qout [NO][$];
    logic [NI-1:0] exp_ur;
    logic [NO-1:0] exp_of;

    proc_io_stream dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .req_in(req_in), .io_in(io_in), .out_en(out_en), .io_out(io_out),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .clr_err(clr_err),
        .underrun(underrun), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic check_outputs();
        logic [BI-1:0]    e_io;
        logic [NI-1:0]    e_sr;
        logic [NO-1:0]    e_mv;
        logic [NO*BO-1:0] e_md;
        logic [NO*BO-1:0] mask;
        int rs;
        rs   = lowest(req_in);
        e_io = '0;
        if (rs >= 0 && qin[rs].size() > 0) e_io = qin[rs][0];
        e_md = '0;
        mask = '0;
        for (int k = 0; k < NI; k++) e_sr[k] = (qin[k].size() != FD);
        for (int k = 0; k < NO; k++) begin
            e_mv[k] = (qout[k].size() != 0);
            if (e_mv[k]) begin
                e_md[k*BO +: BO] = qout[k][0];
                mask[k*BO +: BO] = {BO{1'b1}};
            end
        end
        check_eq("io_in",    128'(io_in),          128'(e_io));
        check_eq("s_ready",  128'(s_ready),        128'(e_sr));
        check_eq("m_valid",  128'(m_valid),        128'(e_mv));
        check_eq("m_data",   128'(m_data & mask),  128'(e_md));
        check_eq("underrun", 128'(underrun),       128'(exp_ur));
        check_eq("overflow", 128'(overflow),       128'(exp_of));
    endtask

    task automatic model_update();
        int isz [NI];
        int osz [NO];
        int rs;
        int ws;
        logic [NI-1:0] ur_set;
        logic [NO-1:0] of_set;
        logic [BI-1:0] di;
        logic [BO-1:0] dout;
        for (int k = 0; k < NI; k++) isz[k] = qin[k].size();
        for (int k = 0; k < NO; k++) osz[k] = qout[k].size();
        rs = lowest(req_in);
        ws = lowest(out_en);
        ur_set = '0;
        of_set = '0;
        if (rs >= 0) begin
            if (isz[rs] > 0) di = qin[rs].pop_front();
            else ur_set[rs] = 1'b1;
        end
        for (int k = 0; k < NI; k++)
            if (s_valid[k] && isz[k] < FD) qin[k].push_back(s_data[k*BI +: BI]);
        for (int k = 0; k < NO; k++)
            if (osz[k] > 0 && m_ready[k]) dout = qout[k].pop_front();
        if (ws >= 0) begin
            if (osz[ws] < FD) qout[ws].push_back(io_out);
            else of_set[ws] = 1'b1;
        end
        exp_ur = (clr_err ? '0 : exp_ur) | ur_set;
        exp_of = (clr_err ? '0 : exp_of) | of_set;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) qin[k].delete();
        for (int k = 0; k < NO; k++) qout[k].delete();
        exp_ur = '0;
        exp_of = '0;
    endtask

    task automatic idle();
        s_data = '0; s_valid = '0; req_in = '0; out_en = '0;
        io_out = '0; m_ready = '0; clr_err = 1'b0;
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic cyc();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic push_in(input int port, input logic [BI-1:0] val);
        idle();
        s_valid[port] = 1'b1;
        s_data[port*BI +: BI] = val;
        cyc();
    endtask

    function automatic logic [3:0] rand_strobe();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return 4'(1 << r);
        if (r < 6) return 4'($urandom);
        return 4'b0000;
    endfunction

    initial begin
        rst = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Three words through port 2, read back in strobe cycles.
        push_in(2, 19'h00001);
        push_in(2, 19'h7FFFF);
        push_in(2, 19'h40000);
        for (int i = 0; i < 3; i++) begin idle(); req_in = 4'b0100; cyc(); end

        // Fill port 0 past capacity, then read across the pointer wrap.
        for (int i = 0; i < 9; i++) push_in(0, 19'($urandom));
        for (int i = 0; i < 9; i++) begin idle(); req_in = 4'b0001; cyc(); end

        // Empty read on port 3, clear, then clear colliding with a new underrun.
        idle(); req_in = 4'b1000; cyc();
        idle(); clr_err = 1'b1; cyc();
        idle(); req_in = 4'b1000; cyc();
        idle(); req_in = 4'b1000; clr_err = 1'b1; cyc();
        idle(); cyc();

        // Output port 1: nine writes with sink stalled, then drain.
        for (int i = 0; i < 9; i++) begin
            idle(); out_en = 4'b0010;
            io_out = (i == 0) ? 28'h8000001 : 28'($urandom);
            cyc();
        end
        for (int i = 0; i < 9; i++) begin idle(); m_ready = 4'b1111; cyc(); end

        // Multi-hot read strobe: only the lowest port pops.
        for (int i = 0; i < 2; i++) begin
            idle(); s_valid = 4'b0110; s_data = {$urandom, $urandom, $urandom};
            cyc();
        end
        idle(); req_in = 4'b0110; cyc();
        for (int i = 0; i < 3; i++) begin idle(); req_in = 4'b0100; cyc(); end
        idle(); clr_err = 1'b1; cyc();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            s_valid = 4'($urandom);
            s_data  = {$urandom, $urandom, $urandom};
            req_in  = rand_strobe();
            out_en  = rand_strobe();
            io_out  = 28'($urandom);
            m_ready = 4'($urandom);
            clr_err = ($urandom_range(0, 19) == 0);
            cyc();
        end

        // Half-fill everything, then reset asynchronously between edges.
        for (int i = 0; i < 4; i++) begin
            idle(); s_valid = 4'b1111; s_data = {$urandom, $urandom, $urandom};
            out_en = 4'(1 << i); io_out = 28'($urandom);
            cyc();
        end
        idle(); req_in = 4'b1000; cyc();
        s_valid = 4'b1111; out_en = 4'b0001; req_in = 4'b0001;
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs();
        idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(); req_in = 4'b0001; cyc();
        idle(); cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
